// File: rtl/rw_pkg.sv
// Shared types and line-level constants for the read/write transmit path.
// The PARITY state is always enumerated; only tx_serializer decides whether to use it.
package rw_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE
  } tx_state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Counter width for a 0..n-1 range, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tx_serializer_bit_timer.sv
// bit_timer: free-running BIT_CYCLES divider with a synchronous clear.
// bit_tick is high while the count sits on its terminal value BIT_CYCLES-1.
module bit_timer
  import rw_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clear,
  output logic bit_tick
);

  localparam int unsigned CW = cnt_width(BIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (clear || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign bit_tick = (count == LAST);

endmodule

// File: rtl/tx_serializer.sv
// tx_serializer: framed bit-serial transmitter (start, data LSB first, [parity], stop).
// Define TX_PARITY_EN to add an even-parity bit between the data and the stop bit.
module tx_serializer
  import rw_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              TxData,
  input  logic [DATA_W-1:0] DataIn,
  output logic              SOut,
  output logic              TxDone,
  output logic              TxBusy
);

  localparam int unsigned BW = cnt_width(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  tx_state_e         state, state_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic [BW-1:0]     bitcnt, bitcnt_nxt;
  logic              txdata_q;
  logic              start;
  logic              bit_tick;
  logic              sout_nxt;
`ifdef TX_PARITY_EN
  logic              parity_q, parity_nxt;
`endif

  // A request only counts as a rising edge seen while idle; edges during a frame are dropped.
  assign start = (state == IDLE) && TxData && !txdata_q;

  // Holding the divider clear while idle aligns its first tick with the end of the start bit.
  bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .Clk      (Clk),
    .Reset    (Reset),
    .clear    (state == IDLE),
    .bit_tick (bit_tick)
  );

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
    state_nxt  = state;
    shreg_nxt  = shreg;
    bitcnt_nxt = bitcnt;
`ifdef TX_PARITY_EN
    parity_nxt = parity_q;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt  = START;
          shreg_nxt  = DataIn;
          bitcnt_nxt = '0;
`ifdef TX_PARITY_EN
          parity_nxt = ^DataIn;
`endif
        end
      end
      START: begin
        if (bit_tick) state_nxt = DATA;
      end
      DATA: begin
        if (bit_tick) begin
          shreg_nxt = shreg >> 1;
          if (bitcnt == LAST_BIT) begin
`ifdef TX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end else begin
            bitcnt_nxt = bitcnt + BW'(1);
          end
        end
      end
`ifdef TX_PARITY_EN
      PARITY: begin
        if (bit_tick) state_nxt = STOP;
      end
`endif
      STOP: begin
        if (bit_tick) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Outputs are registered, so the line level is decoded from the next state.
    sout_nxt = LINE_IDLE;
    case (state_nxt)
      START:   sout_nxt = START_BIT;
      DATA:    sout_nxt = shreg_nxt[0];
`ifdef TX_PARITY_EN
      PARITY:  sout_nxt = parity_nxt;
`endif
      STOP:    sout_nxt = STOP_BIT;
      DONE:    sout_nxt = STOP_BIT;
      default: sout_nxt = LINE_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      shreg    <= '0;
      bitcnt   <= '0;
      // A request held high through reset must not look like a fresh rising edge.
      txdata_q <= 1'b1;
      SOut     <= LINE_IDLE;
      TxDone   <= 1'b0;
      TxBusy   <= 1'b0;
`ifdef TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      bitcnt   <= bitcnt_nxt;
      txdata_q <= TxData;
      SOut     <= sout_nxt;
      TxDone   <= (state_nxt == DONE);
      TxBusy   <= (state_nxt != IDLE);
`ifdef TX_PARITY_EN
      parity_q <= parity_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_tx_serializer.sv
// Scoreboard bench for tx_serializer: one instance at BIT_CYCLES=4, one at BIT_CYCLES=1.
// Frames are checked when TxDone appears, against a per-cycle history of SOut and TxBusy.
module tb_tx_serializer;

`ifdef TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int F = PAR ? 11 : 10;
  localparam int HIST = 2048;

  // Expected frames, bit 0 = first bit on the line; parity bits computed by hand.
  localparam logic [10:0] FR_A5 = PAR ? {1'b1, 1'b0, 8'hA5, 1'b0} : {2'b01, 8'hA5, 1'b0};
  localparam logic [10:0] FR_07 = PAR ? {1'b1, 1'b1, 8'h07, 1'b0} : {2'b01, 8'h07, 1'b0};
  localparam logic [10:0] FR_3C = PAR ? {1'b1, 1'b0, 8'h3C, 1'b0} : {2'b01, 8'h3C, 1'b0};
  localparam logic [10:0] FR_80 = PAR ? {1'b1, 1'b1, 8'h80, 1'b0} : {2'b01, 8'h80, 1'b0};
  localparam logic [10:0] FR_5A = PAR ? {1'b1, 1'b0, 8'h5A, 1'b0} : {2'b01, 8'h5A, 1'b0};
  localparam logic [10:0] FR_C3 = PAR ? {1'b1, 1'b0, 8'hC3, 1'b0} : {2'b01, 8'hC3, 1'b0};

  typedef struct {
    int          n;
    logic [10:0] frame;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       td [2];
  logic [7:0] di [2];
  logic       so [2];
  logic       done [2];
  logic       busy [2];

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t q0 [$];
  exp_t q1 [$];
  logic sout_h [2][0:HIST-1];
  logic busy_h [2][0:HIST-1];
  bit   fall_pend [2];

  tx_serializer #(.DATA_W(8), .BIT_CYCLES(4)) u_dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .TxData (td[0]),
    .DataIn (di[0]),
    .SOut   (so[0]),
    .TxDone (done[0]),
    .TxBusy (busy[0])
  );

  tx_serializer #(.DATA_W(8), .BIT_CYCLES(1)) u_fast (
    .Clk    (Clk),
    .Reset  (Reset),
    .TxData (td[1]),
    .DataIn (di[1]),
    .SOut   (so[1]),
    .TxDone (done[1]),
    .TxBusy (busy[1])
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called by the monitor when TxDone is seen at cycle c.
  task automatic check_done(input int inst, input int c);
    exp_t        e;
    int          bc;
    int          glitches;
    int          busy_err;
    logic [10:0] got;
    if ((inst == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_done[%0d]: TxDone at cycle %0d, expected none", inst, c);
      return;
    end
    e = (inst == 0) ? q0.pop_front() : q1.pop_front();
    bc = (inst == 0) ? 4 : 1;
    check($sformatf("done_cycle[%0d]", inst), c - e.n, F * bc + 1);
    got = '0;
    glitches = 0;
    busy_err = 0;
    for (int b = 0; b < F; b++) begin
      got[b] = sout_h[inst][e.n + 1 + b * bc];
      for (int k = 0; k < bc; k++)
        if (sout_h[inst][e.n + 1 + b * bc + k] !== e.frame[b]) glitches++;
    end
    for (int x = e.n + 1; x <= c; x++)
      if (busy_h[inst][x] !== 1'b1) busy_err++;
    check($sformatf("frame_bits[%0d]", inst), got, e.frame);
    check($sformatf("bit_glitches[%0d]", inst), glitches, 0);
    check($sformatf("busy_during_frame[%0d]", inst), busy_err, 0);
    fall_pend[inst] = 1'b1;
  endtask

  // Monitor: logs each cycle's outputs, checks frames on TxDone and the cycle after it.
  always @(negedge Clk) begin
    for (int i = 0; i < 2; i++) begin
      automatic int c = cyc + 1;
      if (c < HIST) begin
        sout_h[i][c] = so[i];
        busy_h[i][c] = busy[i];
      end
      if (fall_pend[i]) begin
        fall_pend[i] = 1'b0;
        check($sformatf("busy_falls[%0d]", i), busy[i], 1'b0);
        check($sformatf("line_idle_after[%0d]", i), so[i], 1'b1);
      end
      if (done[i] === 1'b1) check_done(i, c);
    end
  end

  // Raise the request at the current negedge; the next posedge is cycle n.
  task automatic send(input int inst, input logic [7:0] w, input logic [10:0] fr);
    exp_t e;
    e.n = cyc + 1;
    e.frame = fr;
    di[inst] = w;
    td[inst] = 1'b1;
    if (inst == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic wait_done(input int inst, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk);
      #1;
      if (done[inst] === 1'b1) return;
    end
    n_cmp++;
    n_fail++;
    $display("FAIL wait_done_timeout[%0d]: no TxDone within %0d cycles", inst, budget);
  endtask

  task automatic wait_idle(input int inst, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk);
      #1;
      if (((inst == 0) ? q0.size() : q1.size()) == 0 && busy[inst] === 1'b0 && !fall_pend[inst])
        return;
    end
    n_cmp++;
    n_fail++;
    $display("FAIL wait_idle_timeout[%0d]: still busy after %0d cycles", inst, budget);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int extra;
    td[0] = 1'b0; td[1] = 1'b0;
    di[0] = 8'h00; di[1] = 8'h00;

    repeat (3) @(negedge Clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset_sout[%0d]", i), so[i], 1'b1);
      check($sformatf("reset_done[%0d]", i), done[i], 1'b0);
      check($sformatf("reset_busy[%0d]", i), busy[i], 1'b0);
    end
    Reset = 1'b0;
    repeat (2) @(negedge Clk);

    // Basic frame on both; fast instance then restarts at the earliest legal cycle.
    send(0, 8'hA5, FR_A5);
    send(1, 8'h80, FR_80);
    @(negedge Clk);
    td[0] = 1'b0; td[1] = 1'b0;
    wait_done(1, 40);
    @(negedge Clk);
    send(1, 8'hA5, FR_A5);
    @(negedge Clk);
    td[1] = 1'b0;
    wait_done(0, 100);
    @(negedge Clk);
    send(0, 8'h07, FR_07);
    @(negedge Clk);
    td[0] = 1'b0;
    wait_idle(0, 200);
    wait_idle(1, 50);

    // Held request: one frame only, line idle for the rest of the hold.
    @(negedge Clk);
    n0 = cyc + 1;
    send(0, 8'h3C, FR_3C);
    extra = 0;
    repeat (99) begin
      @(negedge Clk);
      #1;
      if ((cyc + 1 > n0 + F * 4 + 2) && (so[0] !== 1'b1 || busy[0] !== 1'b0)) extra++;
    end
    td[0] = 1'b0;
    check("held_request_idle", extra, 0);
    wait_idle(0, 50);

    // Mid-frame re-request and DataIn change are ignored.
    @(negedge Clk);
    n0 = cyc + 1;
    send(0, 8'hA5, FR_A5);
    @(negedge Clk);
    td[0] = 1'b0;
    while (cyc + 1 < n0 + 10) @(negedge Clk);
    td[0] = 1'b1;
    di[0] = 8'hFF;
    repeat (5) @(negedge Clk);
    td[0] = 1'b0;
    wait_idle(0, 200);
    extra = 0;
    repeat (20) begin
      @(negedge Clk);
      #1;
      if (busy[0] !== 1'b0) extra++;
    end
    check("no_second_frame", extra, 0);

    // Reset mid-frame with the request held high through reset.
    @(negedge Clk);
    n0 = cyc + 1;
    send(0, 8'h5A, FR_5A);
    @(negedge Clk);
    td[0] = 1'b0;
    while (cyc + 1 < n0 + 20) @(negedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    check("abort_sout", so[0], 1'b1);
    check("abort_busy", busy[0], 1'b0);
    check("abort_done", done[0], 1'b0);
    q0.delete();
    td[0] = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    extra = 0;
    repeat (15) begin
      @(negedge Clk);
      #1;
      if (busy[0] !== 1'b0 || done[0] !== 1'b0) extra++;
    end
    check("held_through_reset", extra, 0);
    td[0] = 1'b0;
    @(negedge Clk);
    send(0, 8'hC3, FR_C3);
    @(negedge Clk);
    td[0] = 1'b0;
    wait_idle(0, 200);

    repeat (5) @(negedge Clk);
    check("queue0_drained", q0.size(), 0);
    check("queue1_drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_serializer.md
# tx_serializer

Bit-serial transmit stage directly downstream of the read/write flow controller. It accepts a parallel word read from memory when the controller raises `TxData` and shifts it out on `SOut` as a framed serial stream: start bit, data LSB first, optional parity, stop bit. When the stop bit completes, it returns a one-cycle `TxDone` pulse to the controller, which uses it to release `Busy`.

## Interface
- `DATA_W`, default 8: payload width in bits; must be ≥ 1.
- `BIT_CYCLES`, default 4: `Clk` cycles per serial bit; must be ≥ 1.
- `Clk` input 1: clock; all state changes on the rising edge.
- `Reset` input 1: asynchronous, active-high.
- `TxData` input 1: transmit request level from the controller; a frame starts on its rising edge.
- `DataIn` input `DATA_W`: word to send; sampled only on the start cycle.
- `SOut` output 1: serial line; idles high.
- `TxDone` output 1: one-cycle pulse at end of frame.
- `TxBusy` output 1: high while a frame is in progress.

## Operation
- **States:**
  - IDLE → START on a `TxData` rising edge (`TxData`=1 and registered previous value=0).
  - START → DATA after `BIT_CYCLES`.
  - DATA → PARITY (macro on) or STOP after `DATA_W` bits.
  - PARITY → STOP.
  - STOP → DONE.
  - DONE → IDLE after one cycle.
- **Start cycle:** `DataIn` is latched into a `DATA_W` shift register. The bit counter and divider are cleared.
- **SOut by state:**
  - IDLE: 1.
  - START: 0.
  - DATA: shift register bit 0; the register shifts right on each bit boundary.
  - PARITY: even parity (XOR) of the latched word.
  - STOP: 1.
  - DONE: 1.
- **Bit timing:** the divider counts 0..`BIT_CYCLES`-1. The bit boundary is the cycle where the count equals `BIT_CYCLES`-1. The bit counter increments at each DATA boundary; DATA exits when the count reaches `DATA_W`-1 at a boundary.
- **TxDone:** asserted only in DONE.
- **TxBusy:** high in every state except IDLE, including DONE.
- **Rising edges of `TxData` outside IDLE:** ignored and not queued. A held-high `TxData` never starts a second frame; the controller must drop it first.
- **`DataIn` changes after the start cycle:** no effect on the frame in progress.
- **Widths:**
  - Divider: `$clog2(BIT_CYCLES)` bits, minimum 1.
  - Bit counter: `$clog2(DATA_W)` bits, minimum 1.
  - No wrap-around beyond these terminal counts.
- **Reset, asynchronous, mid-frame or otherwise:**
  - State goes to IDLE; `SOut`=1, `TxDone`=0, `TxBusy`=0.
  - Counters and the shift register clear.
  - The registered `TxData` copy resets to 1, so a request held high through reset does not start a frame. No `TxDone` is issued for an aborted frame.

## Timing
- All outputs are registered. Reset values: `SOut`=1, `TxDone`=0, `TxBusy`=0.
- **Frame length:** F = `DATA_W`+2 bits, or `DATA_W`+3 with parity.
- **Reference cycle:** let cycle n be the edge where the rising edge of `TxData` is sampled.
- **START:** `SOut`=0 and `TxBusy`=1 from cycle n+1. The start bit occupies cycles n+1 .. n+`BIT_CYCLES`.
- **Data bit k:** occupies cycles n+1+(k+1)·`BIT_CYCLES` .. n+(k+2)·`BIT_CYCLES`.
- **TxDone:** high exactly at cycle n+F·`BIT_CYCLES`+1. `TxBusy` falls at n+F·`BIT_CYCLES`+2.
- **Earliest next start:** a new rising edge is accepted at cycle n+F·`BIT_CYCLES`+2 at the earliest.
- **`BIT_CYCLES`=1:** each bit lasts exactly one cycle; no idle gap is inserted between states.

## Configuration
- `TX_PARITY_EN` defined: the PARITY state exists, the frame carries an even-parity bit after the data, and F = `DATA_W`+3.
- `TX_PARITY_EN` undefined: PARITY is compiled out, DATA goes directly to STOP, and F = `DATA_W`+2.

## Structure
- **Shared package `rw_pkg`:**
  - Transmitter state enum (IDLE, START, DATA, PARITY, STOP, DONE).
  - Line-level constants: `LINE_IDLE`=1, `START_BIT`=0, `STOP_BIT`=1.
- **Sub-module `bit_timer`:** a parameterised `BIT_CYCLES` divider with a clear input. It outputs a one-cycle `bit_tick` at count `BIT_CYCLES`-1. The divider is the only sub-module; the FSM, shift register and bit counter stay in `tx_serializer`.

## Test plan
All scenarios use `DATA_W`=8, `BIT_CYCLES`=4, parity off, unless stated.
- **Basic frame:** `DataIn`=8'hA5, pulse `TxData` at cycle n.
  - `SOut` per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1.
  - `TxDone` single pulse at n+41.
  - `TxBusy` high n+1..n+41.
- **Parity on:** `TX_PARITY_EN` defined, `DataIn`=8'h07.
  - Parity bit 1 is driven after data bit 7, then the stop bit.
  - `TxDone` at n+45.
- **Held request:** `TxData` held high 100 cycles with `DataIn`=8'h3C. Exactly one frame and one `TxDone`; `SOut` stays 1 afterwards.
- **Ignored mid-frame request:** at n+10, toggle `TxData` low then high and change `DataIn` to 8'hFF. The frame still carries 8'hA5 and no second frame follows.
- **Reset mid-frame:** assert `Reset` at n+20. `SOut`=1, `TxBusy`=0 and `TxDone`=0 immediately (asynchronous), with no `TxDone` after release. The next rising edge transmits a clean full frame.
- **Minimum bit time:** `BIT_CYCLES`=1, `DataIn`=8'h80. `SOut` = 0,0,0,0,0,0,0,0,1,1 on consecutive cycles, and `TxDone` at n+11.
